// File: rtl/timer_channel_ctrl_if.sv
// Register bus for the timer channel: TCR control input plus TCSR write/read port.
interface timer_channel_ctrl_if #(
  parameter int BIT_WIDTH = 8
);
  logic [BIT_WIDTH-1:0] tcr;
  logic [BIT_WIDTH-1:0] tcsr_wdata;
  logic                 tcsr_we;
  logic                 tcsr_rd;
  logic [BIT_WIDTH-1:0] tcsr_rdata;

  modport master (output tcr, tcsr_wdata, tcsr_we, tcsr_rd, input  tcsr_rdata);
  modport slave  (input  tcr, tcsr_wdata, tcsr_we, tcsr_rd, output tcsr_rdata);
endinterface

// File: rtl/timer_channel_ctrl.sv
// Timer channel control: prescaler, clock source select, counter clear, TCSR flags,
// interrupt decode, TMO output logic and ADC trigger.
module timer_channel_ctrl #(
  parameter int BIT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  timer_channel_ctrl_if.slave bus,
  input  logic                tmci,
  input  logic                tmri,
  input  logic                cmp_a,
  input  logic                cmp_b,
  input  logic                ovf,
  output logic                count_en,
  output logic                counter_clear,
  output logic                cmia,
  output logic                cmib,
  output logic                ovi,
  output logic                tmo,
  output logic                adc_req
);

  logic       cmieb, cmiea, ovie;
  logic [1:0] cclr;
  logic [2:0] cks;

  assign {cmieb, cmiea, ovie, cclr, cks} = bus.tcr[7:0];

  function automatic logic apply_os(input logic [1:0] os, input logic cur);
    case (os)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return ~cur;
      default: return cur;
    endcase
  endfunction

  logic [12:0] presc_p0;
  logic        tick8, tick64, tick8192;
  logic        tmci_p0, tmci_p1, tmci_p2;
  logic        tmri_p0, tmri_p1, tmri_p2;
  logic        ext_rise_p3, ext_fall_p3;
  logic        tmri_rise;
  logic        cnt_src, clr_src, tmo_nxt;

  logic [2:0]  flag, arm, flag_set, flag_clr;
  logic        adte;
  logic [1:0]  osb, osa;
  logic [7:0]  tcsr8;

  // Stage p0: free-running prescaler and first synchroniser flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_p0    <= '0;
      tmci_p0     <= 1'b0;
      tmci_p1     <= 1'b0;
      tmci_p2     <= 1'b0;
      tmri_p0     <= 1'b0;
      tmri_p1     <= 1'b0;
      tmri_p2     <= 1'b0;
      ext_rise_p3 <= 1'b0;
      ext_fall_p3 <= 1'b0;
    end else begin
      presc_p0    <= presc_p0 + 13'd1;
      tmci_p0     <= tmci;
      tmci_p1     <= tmci_p0;
      tmci_p2     <= tmci_p1;
      tmri_p0     <= tmri;
      tmri_p1     <= tmri_p0;
      tmri_p2     <= tmri_p1;
      // Stage p3: edges captured continuously so a CKS switch never sees stale history
      ext_rise_p3 <= tmci_p1 & ~tmci_p2;
      ext_fall_p3 <= ~tmci_p1 & tmci_p2;
    end
  end

  assign tick8     = (presc_p0[2:0] == 3'b111);
  assign tick64    = (presc_p0[5:0] == 6'h3f);
  assign tick8192  = &presc_p0;
  assign tmri_rise = tmri_p1 & ~tmri_p2;

  always_comb begin
    cnt_src = 1'b0;
    case (cks)
      3'b001:  cnt_src = tick8;
      3'b010:  cnt_src = tick64;
      3'b011:  cnt_src = tick8192;
      3'b100:  cnt_src = ext_rise_p3;
      3'b101:  cnt_src = ext_fall_p3;
      3'b110:  cnt_src = ext_rise_p3 | ext_fall_p3;
      default: cnt_src = 1'b0;
    endcase
  end

  always_comb begin
    clr_src = 1'b0;
    case (cclr)
      2'b01:   clr_src = cmp_a;
      2'b10:   clr_src = cmp_b;
      2'b11:   clr_src = tmri_rise;
      default: clr_src = 1'b0;
    endcase
  end

  // Compare B has the output when both match, unless its action is "hold"
  always_comb begin
    tmo_nxt = tmo;
    if (cmp_b && (osb != 2'b00)) tmo_nxt = apply_os(osb, tmo);
    else if (cmp_a)              tmo_nxt = apply_os(osa, tmo);
  end

  // Output stage: one-cycle pulses and TMO registered one cycle after their cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_en      <= 1'b0;
      counter_clear <= 1'b0;
      adc_req       <= 1'b0;
      tmo           <= 1'b0;
    end else begin
      count_en      <= cnt_src;
      counter_clear <= clr_src;
      adc_req       <= cmp_a & adte;
      tmo           <= tmo_nxt;
    end
  end

  // Flag order: [2] CMFB, [1] CMFA, [0] OVF, matching TCSR bits 7:5
  assign flag_set = {cmp_b, cmp_a, ovf};
  assign flag_clr = {3{bus.tcsr_we}} & ~bus.tcsr_wdata[7:5] & arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= '0;
      arm  <= '0;
      adte <= 1'b0;
      osb  <= 2'b00;
      osa  <= 2'b00;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (flag_set[i]) begin
          flag[i] <= 1'b1;
          if (flag_clr[i])                arm[i] <= 1'b0;
          else if (bus.tcsr_rd && flag[i]) arm[i] <= 1'b1;
        end else if (flag_clr[i]) begin
          flag[i] <= 1'b0;
          arm[i]  <= 1'b0;
        end else if (bus.tcsr_rd && flag[i]) begin
          arm[i]  <= 1'b1;
        end
      end
      if (bus.tcsr_we) begin
        adte <= bus.tcsr_wdata[4];
        osb  <= bus.tcsr_wdata[3:2];
        osa  <= bus.tcsr_wdata[1:0];
      end
    end
  end

  assign tcsr8          = {flag[2], flag[1], flag[0], adte, osb, osa};
  assign bus.tcsr_rdata = BIT_WIDTH'(tcsr8);

  assign cmia = flag[1] & cmiea;
  assign cmib = flag[2] & cmieb;
  assign ovi  = flag[0] & ovie;

endmodule
